channel_scanner: RTL and testbench

//  Upstream sequencer for the registered N-input selector (simple_interconnect): drives its sel and clken.

---
 rtl/channel_scanner_pkg.sv | 13 +
 rtl/channel_scanner_if.sv | 29 ++
 rtl/channel_scanner_counter.sv | 26 ++
 rtl/channel_scanner.sv | 167 ++++++++++++++++
 tb/tb_channel_scanner.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/channel_scanner_pkg.sv
// rtl/channel_scanner_pkg.sv - shared state and mode encodings for the channel scanner
package channel_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2
    } state_t;

    localparam logic MODE_SCAN   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

endpackage

// File: rtl/channel_scanner_if.sv
// rtl/channel_scanner_if.sv - control/status bundle between host and channel scanner
interface channel_scanner_if #(
    parameter int SEL_WIDTH = 2,
    parameter int CNT_WIDTH = 16
);
    logic                 cfg_mode;
    logic [SEL_WIDTH-1:0] cfg_manual_sel;
    logic [SEL_WIDTH-1:0] cfg_last_ch;
    logic [CNT_WIDTH-1:0] cfg_settle;
    logic [CNT_WIDTH-1:0] cfg_dwell;
    logic                 start;
    logic                 stop;
    logic [SEL_WIDTH-1:0] sel;
    logic                 clken;
    logic                 valid;
    logic [SEL_WIDTH-1:0] ch_tag;
    logic                 frame_done;
    logic                 busy;

    modport master (
        output cfg_mode, cfg_manual_sel, cfg_last_ch, cfg_settle, cfg_dwell, start, stop,
        input  sel, clken, valid, ch_tag, frame_done, busy
    );

    modport slave (
        input  cfg_mode, cfg_manual_sel, cfg_last_ch, cfg_settle, cfg_dwell, start, stop,
        output sel, clken, valid, ch_tag, frame_done, busy
    );
endinterface

// File: rtl/channel_scanner_counter.sv
// rtl/channel_scanner_counter.sv - loadable down-counter timing both settle and dwell phases
module scan_down_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic                 terminal
);
    logic [CNT_WIDTH-1:0] count;

    // Count holds the cycles remaining in the current phase, including this one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign terminal = (count <= CNT_WIDTH'(1));
endmodule

// File: rtl/channel_scanner.sv
// rtl/channel_scanner.sv - round-robin/manual sel+clken sequencer for a registered selector
module channel_scanner
    import channel_scanner_pkg::*;
#(
    parameter int N_INPUTS  = 3,
    parameter int SEL_WIDTH = 2,
    parameter int CNT_WIDTH = 16
) (
    input logic            clk,
    input logic            resetn,
    channel_scanner_if.slave bus
);
    localparam logic [SEL_WIDTH-1:0] MAX_CH = SEL_WIDTH'(N_INPUTS - 1);
    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

    state_t               state;
    logic                 mode;
    logic [SEL_WIDTH-1:0] last_ch;
    logic [CNT_WIDTH-1:0] settle_len;
    logic [CNT_WIDTH-1:0] dwell_len;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [SEL_WIDTH-1:0] tag_q;
    logic                 clken_q;
    logic                 valid_q;
    logic                 frame_q;
    logic                 busy_q;

    logic [SEL_WIDTH-1:0] cfg_last_clamped;
    logic [SEL_WIDTH-1:0] cfg_manual_clamped;
    logic [CNT_WIDTH-1:0] cfg_dwell_eff;
    logic [SEL_WIDTH-1:0] next_sel;
    logic                 cnt_load;
    logic                 cnt_enable;
    logic [CNT_WIDTH-1:0] cnt_value;
    logic                 cnt_tc;

    assign cfg_last_clamped   = (bus.cfg_last_ch > MAX_CH) ? MAX_CH : bus.cfg_last_ch;
    assign cfg_manual_clamped = (bus.cfg_manual_sel > MAX_CH) ? MAX_CH : bus.cfg_manual_sel;
    assign cfg_dwell_eff      = (bus.cfg_dwell == '0) ? ONE : bus.cfg_dwell;
    assign next_sel           = (sel_q == last_ch) ? '0 : sel_q + SEL_WIDTH'(1);

    // Decide when the shared counter reloads for a new phase or simply counts down.
    always_comb begin
        cnt_load   = 1'b0;
        cnt_enable = 1'b0;
        cnt_value  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_load  = 1'b1;
                    cnt_value = (bus.cfg_settle != '0) ? bus.cfg_settle : cfg_dwell_eff;
                end
            end
            ST_SETTLE: begin
                if (cnt_tc) begin
                    cnt_load  = 1'b1;
                    cnt_value = dwell_len;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            ST_DWELL: begin
                if (mode == MODE_SCAN) begin
                    if (cnt_tc) begin
                        cnt_load  = 1'b1;
                        cnt_value = (settle_len != '0) ? settle_len : dwell_len;
                    end else begin
                        cnt_enable = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    scan_down_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
        .clk        (clk),
        .resetn     (resetn),
        .load       (cnt_load),
        .enable     (cnt_enable),
        .load_value (cnt_value),
        .terminal   (cnt_tc)
    );

    // Main sequencer: config latch on start, settle/dwell phases, channel advance, stop abort.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            mode       <= MODE_SCAN;
            last_ch    <= '0;
            settle_len <= '0;
            dwell_len  <= '0;
            sel_q      <= '0;
            clken_q    <= 1'b0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else if (bus.stop) begin
            state   <= ST_IDLE;
            clken_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode       <= bus.cfg_mode;
                        last_ch    <= cfg_last_clamped;
                        settle_len <= bus.cfg_settle;
                        dwell_len  <= cfg_dwell_eff;
                        sel_q      <= (bus.cfg_mode == MODE_MANUAL) ? cfg_manual_clamped : '0;
                        busy_q     <= 1'b1;
                        if (bus.cfg_settle == '0) begin
                            state   <= ST_DWELL;
                            clken_q <= 1'b1;
                        end else begin
                            state   <= ST_SETTLE;
                            clken_q <= 1'b0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_tc) begin
                        state   <= ST_DWELL;
                        clken_q <= 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (mode == MODE_SCAN && cnt_tc) begin
                        sel_q   <= next_sel;
                        frame_q <= (sel_q == last_ch);
                        if (settle_len == '0) begin
                            state   <= ST_DWELL;
                            clken_q <= 1'b1;
                        end else begin
                            state   <= ST_SETTLE;
                            clken_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    clken_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle alignment with the selector's registered output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= clken_q;
            tag_q   <= sel_q;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.clken      = clken_q;
    assign bus.valid      = valid_q;
    assign bus.ch_tag     = tag_q;
    assign bus.frame_done = frame_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_channel_scanner.sv
// tb/tb_channel_scanner.sv - self-checking bench for channel_scanner with a registered 3-input selector
module tb_channel_scanner;
    localparam int N_INPUTS  = 3;
    localparam int SEL_WIDTH = 2;
    localparam int CNT_WIDTH = 16;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    channel_scanner_if #(.SEL_WIDTH(SEL_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    channel_scanner #(.N_INPUTS(N_INPUTS), .SEL_WIDTH(SEL_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Registered selector (WIDTH=8) fed by the scanner, inputs {30,20,10}.
    logic [7:0] in_data [N_INPUTS] = '{8'h10, 8'h20, 8'h30};
    logic [7:0] sel_out = 8'h00;
    always @(posedge clk) begin
        if (bus.clken) sel_out <= in_data[bus.sel];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per-cycle outputs from the run's cycle index j after start.
    bit running = 0;
    int m_mode, m_ms, m_last, m_s, m_d, j;
    int e_sel = 0, e_clk = 0, e_fd = 0, e_busy = 0, e_valid = 0, e_tag = 0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_eval();
        int per;
        e_busy = 1;
        if (m_mode == 1) begin
            e_sel = m_ms;
            e_clk = (j >= m_s) ? 1 : 0;
            e_fd  = 0;
        end else begin
            per   = m_s + m_d;
            e_sel = (j / per) % (m_last + 1);
            e_clk = ((j % per) >= m_s) ? 1 : 0;
            e_fd  = (j > 0 && (j % (per * (m_last + 1))) == 0) ? 1 : 0;
        end
    endtask

    always @(posedge clk) begin
        if (!resetn) begin
            running = 0;
            e_sel = 0; e_clk = 0; e_fd = 0; e_busy = 0; e_valid = 0; e_tag = 0;
        end else begin
            e_valid = e_clk;
            e_tag   = e_sel;
            if (bus.stop) begin
                running = 0;
                e_clk = 0; e_fd = 0; e_busy = 0;
            end else if (!running && bus.start) begin
                m_mode  = int'(bus.cfg_mode);
                m_ms    = imin(int'(bus.cfg_manual_sel), N_INPUTS - 1);
                m_last  = imin(int'(bus.cfg_last_ch), N_INPUTS - 1);
                m_s     = int'(bus.cfg_settle);
                m_d     = (bus.cfg_dwell == 0) ? 1 : int'(bus.cfg_dwell);
                running = 1;
                j       = 0;
                model_eval();
            end else if (running) begin
                j++;
                model_eval();
            end else begin
                e_fd = 0;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        chk("sel", 32'(bus.sel), 32'(e_sel));
        chk("clken", 32'(bus.clken), 32'(e_clk));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("valid", 32'(bus.valid), 32'(e_valid));
        chk("ch_tag", 32'(bus.ch_tag), 32'(e_tag));
        if (e_valid == 1) chk("sel_out", 32'(sel_out), 32'(8'h10 * (e_tag + 1)));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick(1); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
    endtask

    task automatic set_cfg(input int mode, input int msel, input int last, input int s, input int d);
        bus.cfg_mode       = mode[0];
        bus.cfg_manual_sel = SEL_WIDTH'(msel);
        bus.cfg_last_ch    = SEL_WIDTH'(last);
        bus.cfg_settle     = CNT_WIDTH'(s);
        bus.cfg_dwell      = CNT_WIDTH'(d);
    endtask

    int fd_count;

    initial begin
        resetn = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(0, 0, 2, 2, 3);

        // 1) Reset
        tick(5);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_clken", 32'(bus.clken), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_ch_tag", 32'(bus.ch_tag), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        pulse_start();
        chk("rst_start_busy", 32'(bus.busy), 0);
        resetn = 1'b1;
        tick(2);

        // 2) Scan S=2 D=3 last=2
        set_cfg(0, 0, 2, 2, 3);
        pulse_start();
        chk("scan_clken_t1", 32'(bus.clken), 0);
        chk("scan_busy_t1", 32'(bus.busy), 1);
        tick(2);
        chk("scan_clken_t3", 32'(bus.clken), 1);
        fd_count = 0;
        for (int i = 0; i < 45; i++) begin
            tick(1);
            if (bus.frame_done) fd_count++;
        end
        chk("scan_frame_count", 32'(fd_count), 3);
        pulse_stop();
        tick(2);

        // 3) Zero settle S=0 D=1 last=2
        set_cfg(0, 0, 2, 0, 1);
        pulse_start();
        chk("zs_clken_t1", 32'(bus.clken), 1);
        tick(1);
        chk("zs_sel_t2", 32'(bus.sel), 1);
        chk("zs_tag_t2", 32'(bus.ch_tag), 0);
        tick(6);
        pulse_stop();
        tick(2);

        // 4) Manual ch1, S=4
        set_cfg(1, 1, 2, 4, 5);
        pulse_start();
        fd_count = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bus.frame_done) fd_count++;
        end
        chk("man_clken", 32'(bus.clken), 1);
        chk("man_sel", 32'(bus.sel), 1);
        chk("man_out", 32'(sel_out), 32'h20);
        chk("man_no_frame", 32'(fd_count), 0);
        pulse_stop();
        tick(2);

        // 5) stop mid-DWELL on ch1 together with start
        set_cfg(0, 0, 2, 2, 3);
        pulse_start();
        tick(8);
        bus.stop = 1'b1; bus.start = 1'b1;
        tick(1);
        bus.stop = 1'b0; bus.start = 1'b0;
        chk("stop_clken", 32'(bus.clken), 0);
        chk("stop_busy", 32'(bus.busy), 0);
        chk("stop_sel", 32'(bus.sel), 1);
        tick(3);
        pulse_start();
        chk("restart_sel", 32'(bus.sel), 0);
        tick(4);
        pulse_stop();
        tick(2);

        // 6) Clamping last=3 -> 2, dwell 0 -> 1, cfg change while busy ignored
        set_cfg(0, 0, 3, 1, 0);
        pulse_start();
        bus.cfg_dwell = CNT_WIDTH'(7);
        bus.cfg_last_ch = SEL_WIDTH'(1);
        tick(4);
        chk("clamp_sel_t5", 32'(bus.sel), 2);
        tick(1);
        chk("clamp_clken_t6", 32'(bus.clken), 1);
        tick(1);
        chk("clamp_sel_t7", 32'(bus.sel), 0);
        chk("clamp_frame_t7", 32'(bus.frame_done), 1);
        tick(20);
        pulse_stop();
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
